// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, frame-checker state encoding
// and the legal data-width range.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP1  = 3'd3,
        ST_STOP2  = 3'd4
    } fc_state_t;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_frame_checker_if.sv
// Bit-sampler / frame-checker link: strobed sample bits and frame config in,
// completed word with error flags out.
interface uart_frame_checker_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  BIT_VALID;
    logic                  SAMPLED_BIT;
    logic                  PARITY_EN;
    logic [1:0]            PARITY_MODE;
    logic                  STOP2;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STOP_ERR;
    logic                  BUSY;

    modport master (
        output BIT_VALID, SAMPLED_BIT, PARITY_EN, PARITY_MODE, STOP2,
        input  DATA_OUT, DATA_VALID, PAR_ERR, STOP_ERR, BUSY
    );

    modport slave (
        input  BIT_VALID, SAMPLED_BIT, PARITY_EN, PARITY_MODE, STOP2,
        output DATA_OUT, DATA_VALID, PAR_ERR, STOP_ERR, BUSY
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Expected parity bit for a frame, given the running XOR of its data bits.
// Shared between the RX frame checker and the TX framer.
module uart_parity_calc
    import uart_pkg::*;
(
    input  logic      acc_bit,
    input  par_mode_t mode,
    output logic      parity_bit
);

    always_comb begin
        parity_bit = 1'b0;
        unique case (mode)
            PAR_EVEN:  parity_bit = acc_bit;
            PAR_ODD:   parity_bit = ~acc_bit;
            PAR_MARK:  parity_bit = 1'b1;
            PAR_SPACE: parity_bit = 1'b0;
            default:   parity_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_frame_checker.sv
// UART RX frame checker: assembles an LSB-first word from strobed sample bits,
// checks parity and stop bits, and emits the word with error flags as a one-cycle pulse.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  ST_IDLE   | line idle, waiting for a start bit (sample 0)
//  ST_DATA   | shifting in DATA_WIDTH data bits
//  ST_PARITY | sampling and checking the parity bit
//  ST_STOP1  | sampling the first stop bit
//  ST_STOP2  | sampling the second stop bit (two-stop frames)
module uart_frame_checker
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic CLK,
    input  logic RST,
    uart_frame_checker_if.slave bus
);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
        $error("uart_frame_checker: DATA_WIDTH %0d outside legal range", DATA_WIDTH);
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    fc_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  acc_q, acc_d;
    logic                  cfg_par_en_q, cfg_par_en_d;
    par_mode_t             cfg_mode_q, cfg_mode_d;
    logic                  cfg_stop2_q, cfg_stop2_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_out_q, par_err_out_d;
    logic                  stop_err_out_q, stop_err_out_d;
    logic                  busy_q, busy_d;

    logic                  exp_parity;
    logic                  complete;

    uart_parity_calc u_parity_calc (
        .acc_bit    (acc_q),
        .mode       (cfg_mode_q),
        .parity_bit (exp_parity)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        acc_d          = acc_q;
        cfg_par_en_d   = cfg_par_en_q;
        cfg_mode_d     = cfg_mode_q;
        cfg_stop2_d    = cfg_stop2_q;
        par_err_d      = par_err_q;
        stop_err_d     = stop_err_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        par_err_out_d  = par_err_out_q;
        stop_err_out_d = stop_err_out_q;
        busy_d         = busy_q;
        complete       = 1'b0;

        if (bus.BIT_VALID) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!bus.SAMPLED_BIT) begin
                        cfg_par_en_d = bus.PARITY_EN;
                        cfg_mode_d   = par_mode_t'(bus.PARITY_MODE);
                        cfg_stop2_d  = bus.STOP2;
                        cnt_d        = '0;
                        acc_d        = 1'b0;
                        par_err_d    = 1'b0;
                        stop_err_d   = 1'b0;
                        busy_d       = 1'b1;
                        state_d      = ST_DATA;
                    end
                end
                ST_DATA: begin
                    shift_d = {bus.SAMPLED_BIT, shift_q[DATA_WIDTH-1:1]};
                    acc_d   = acc_q ^ bus.SAMPLED_BIT;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    par_err_d = (bus.SAMPLED_BIT != exp_parity);
                    state_d   = ST_STOP1;
                end
                ST_STOP1: begin
                    stop_err_d = ~bus.SAMPLED_BIT;
                    if (cfg_stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        complete = 1'b1;
                    end
                end
                ST_STOP2: begin
                    stop_err_d = stop_err_q | ~bus.SAMPLED_BIT;
                    complete   = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Frames complete even with errors; downstream decides whether to drop them.
        if (complete) begin
            state_d        = ST_IDLE;
            busy_d         = 1'b0;
            data_valid_d   = 1'b1;
            data_out_d     = shift_q;
            par_err_out_d  = cfg_par_en_q & par_err_q;
            stop_err_out_d = stop_err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            acc_q          <= 1'b0;
            cfg_par_en_q   <= 1'b0;
            cfg_mode_q     <= PAR_EVEN;
            cfg_stop2_q    <= 1'b0;
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            par_err_out_q  <= 1'b0;
            stop_err_out_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            acc_q          <= acc_d;
            cfg_par_en_q   <= cfg_par_en_d;
            cfg_mode_q     <= cfg_mode_d;
            cfg_stop2_q    <= cfg_stop2_d;
            par_err_q      <= par_err_d;
            stop_err_q     <= stop_err_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            par_err_out_q  <= par_err_out_d;
            stop_err_out_q <= stop_err_out_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.DATA_OUT   = data_out_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_out_q;
    assign bus.STOP_ERR   = stop_err_out_q;
    assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed bench for uart_frame_checker at DATA_WIDTH 8 and 7; completed frames
// are checked against a scoreboard of expected words and error flags.
module tb_uart_frame_checker;
    import uart_pkg::*;

    logic CLK;
    logic RST;

    uart_frame_checker_if #(.DATA_WIDTH(8)) bus8 ();
    uart_frame_checker_if #(.DATA_WIDTH(7)) bus7 ();

    uart_frame_checker #(.DATA_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
    uart_frame_checker #(.DATA_WIDTH(7)) dut7 (.CLK(CLK), .RST(RST), .bus(bus7));

    typedef struct packed {
        logic [8:0] data;
        logic       par_err;
        logic       stop_err;
    } exp_t;

    exp_t q8[$];
    exp_t q7[$];
    int   checks = 0;
    int   failures = 0;
    int   vcount8 = 0;
    int   vcount7 = 0;
    int   pushed8 = 0;
    int   pushed7 = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_par(input logic [8:0] d, input int w, input logic [1:0] m);
        logic x;
        x = 1'b0;
        for (int i = 0; i < w; i++) x = x ^ d[i];
        case (m)
            2'b00:   return x;
            2'b01:   return ~x;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_cfg(input int which, input logic en, input logic [1:0] mode, input logic s2);
        if (which == 8) begin
            bus8.PARITY_EN = en; bus8.PARITY_MODE = mode; bus8.STOP2 = s2;
        end else begin
            bus7.PARITY_EN = en; bus7.PARITY_MODE = mode; bus7.STOP2 = s2;
        end
    endtask

    task automatic drive(input int which, input logic bv, input logic b);
        if (which == 8) begin
            bus8.BIT_VALID = bv; bus8.SAMPLED_BIT = b;
        end else begin
            bus7.BIT_VALID = bv; bus7.SAMPLED_BIT = b;
        end
    endtask

    // Called at a negedge; returns at the negedge after the strobe is consumed.
    task automatic strobe(input int which, input logic b, input int gap);
        drive(which, 1'b0, 1'b1);
        repeat (gap) @(negedge CLK);
        drive(which, 1'b1, b);
        @(negedge CLK);
        drive(which, 1'b0, 1'b1);
    endtask

    task automatic send_frame(input int which, input int w, input logic [8:0] data,
                              input logic par_en, input logic [1:0] mode, input logic [1:0] mode_late,
                              input logic s2, input logic par_bit, input logic stop_a,
                              input logic stop_b, input int gap);
        exp_t e;
        e.data     = data & ((9'd1 << w) - 9'd1);
        e.par_err  = par_en && (par_bit != model_par(data, w, mode));
        e.stop_err = !stop_a || (s2 && !stop_b);
        if (which == 8) begin q8.push_back(e); pushed8++; end
        else            begin q7.push_back(e); pushed7++; end

        set_cfg(which, par_en, mode, s2);
        strobe(which, 1'b0, gap);
        set_cfg(which, !par_en, mode_late, !s2);
        check($sformatf("busy_after_start_w%0d", w),
              (which == 8) ? bus8.BUSY : bus7.BUSY, 1);
        for (int i = 0; i < w; i++) strobe(which, data[i], gap);
        if (par_en) strobe(which, par_bit, gap);
        strobe(which, stop_a, gap);
        if (s2) strobe(which, stop_b, gap);
        check($sformatf("valid_latency_%0h", data),
              (which == 8) ? bus8.DATA_VALID : bus7.DATA_VALID, 1);
        check($sformatf("busy_done_%0h", data),
              (which == 8) ? bus8.BUSY : bus7.BUSY, 0);
    endtask

    always @(negedge CLK) begin
        if (!RST && bus8.DATA_VALID) begin
            exp_t e;
            vcount8++;
            check("sb8_nonempty", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("dut8_data", 32'(bus8.DATA_OUT), 32'(e.data));
                check("dut8_par_err", 32'(bus8.PAR_ERR), 32'(e.par_err));
                check("dut8_stop_err", 32'(bus8.STOP_ERR), 32'(e.stop_err));
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && bus7.DATA_VALID) begin
            exp_t e;
            vcount7++;
            check("sb7_nonempty", 32'(q7.size() != 0), 1);
            if (q7.size() != 0) begin
                e = q7.pop_front();
                check("dut7_data", 32'(bus7.DATA_OUT), 32'(e.data));
                check("dut7_par_err", 32'(bus7.PAR_ERR), 32'(e.par_err));
                check("dut7_stop_err", 32'(bus7.STOP_ERR), 32'(e.stop_err));
            end
        end
    end

    initial begin
        RST = 1'b1;
        drive(8, 1'b0, 1'b1);
        drive(7, 1'b0, 1'b1);
        set_cfg(8, 1'b0, PAR_EVEN, 1'b0);
        set_cfg(7, 1'b0, PAR_EVEN, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        check("rst_data_out", 32'(bus8.DATA_OUT), 0);
        check("rst_data_valid", 32'(bus8.DATA_VALID), 0);
        check("rst_par_err", 32'(bus8.PAR_ERR), 0);
        check("rst_stop_err", 32'(bus8.STOP_ERR), 0);
        check("rst_busy", 32'(bus8.BUSY), 0);

        // Idle-line samples must not start a frame.
        strobe(8, 1'b1, 0);
        check("idle_bit_no_busy", 32'(bus8.BUSY), 0);

        send_frame(8, 8, 9'h0A5, 1'b1, PAR_EVEN, PAR_ODD, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        @(negedge CLK);
        check("valid_one_cycle", 32'(bus8.DATA_VALID), 0);
        check("data_held", 32'(bus8.DATA_OUT), 32'h0A5);

        send_frame(8, 8, 9'h03C, 1'b1, PAR_ODD,  PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(8, 8, 9'h081, 1'b0, PAR_EVEN, PAR_MARK, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8, 8, 9'h000, 1'b1, PAR_MARK, PAR_SPACE, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        send_frame(8, 8, 9'h0FF, 1'b1, PAR_SPACE, PAR_MARK, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        send_frame(8, 8, 9'h00F, 1'b1, PAR_EVEN, PAR_ODD, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        @(negedge CLK);

        // Reset partway through 0x55: the frame is abandoned.
        set_cfg(8, 1'b1, PAR_EVEN, 1'b0);
        strobe(8, 1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(8, (i % 2 == 0), 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_busy", 32'(bus8.BUSY), 0);
        check("midrst_data_out", 32'(bus8.DATA_OUT), 0);
        check("midrst_valid", 32'(bus8.DATA_VALID), 0);
        @(negedge CLK);
        send_frame(8, 8, 9'h012, 1'b1, PAR_EVEN, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        @(negedge CLK);

        send_frame(7, 7, 9'h07F, 1'b1, PAR_EVEN, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        send_frame(7, 7, 9'h005, 1'b1, PAR_ODD, PAR_SPACE, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        repeat (3) @(negedge CLK);

        check("dut8_valid_count", vcount8, pushed8);
        check("dut7_valid_count", vcount7, pushed7);
        check("sb8_drained", q8.size(), 0);
        check("sb7_drained", q7.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_checker.md
Name: uart_frame_checker

Overview:
Serial receive-side frame checker for the UART RX path. It sits between the RX bit sampler and the RX output register. It accepts one sampled bit per strobe and assembles the data word LSB-first. It computes parity on the fly, checks the parity and stop bits, and presents the word with error flags as a one-cycle valid pulse. It generalises the combinational parity checker in four ways: configurable data width, four parity modes, one or two stop bits, and a full frame state machine.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CNT_WIDTH, $clog2(DATA_WIDTH+1), width of the bit counter (derived; do not override).

Ports:
CLK  input  1  system clock; all logic rises on posedge CLK.
RST  input  1  synchronous, active-high reset.
BIT_VALID  input  1  one-cycle strobe: SAMPLED_BIT is valid this cycle.
SAMPLED_BIT  input  1  mid-bit sample from the RX sampler.
PARITY_EN  input  1  1 = frame carries a parity bit.
PARITY_MODE  input  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
STOP2  input  1  1 = two stop bits, 0 = one stop bit.
DATA_OUT  output  DATA_WIDTH  received word; LSB is the first data bit.
DATA_VALID  output  1  one-cycle pulse when a frame completes.
PAR_ERR  output  1  parity mismatch for the completed frame; 0 when PARITY_EN was 0.
STOP_ERR  output  1  any stop bit sampled as 0.
BUSY  output  1  high from the accepted start bit until the frame completes.

Behaviour:
- Reset (RST=1 at posedge CLK): FSM goes to IDLE. DATA_OUT=0, DATA_VALID=0, PAR_ERR=0, STOP_ERR=0, BUSY=0. Bit counter, shift register and parity accumulator clear. A reset mid-frame abandons the frame and produces no DATA_VALID.
- All outputs are registered. The FSM advances only on cycles with BIT_VALID=1; cycles without BIT_VALID hold all state.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - BIT_VALID with SAMPLED_BIT=0 is a start bit. Latch PARITY_EN, PARITY_MODE and STOP2 into config registers, clear counter and accumulator, set BUSY=1, go to DATA.
  - SAMPLED_BIT=1 is line idle; stay in IDLE.
- DATA:
  - Each strobe shifts SAMPLED_BIT into the MSB of the shift register (right shift). After DATA_WIDTH strobes the first bit sits at bit 0.
  - Each strobe XORs SAMPLED_BIT into the accumulator and increments the counter.
  - On the strobe where the counter reaches DATA_WIDTH-1, go to PARITY if latched PARITY_EN=1, else STOP1.
- PARITY: expected bit is chosen by the latched mode.
  - even: accumulator
  - odd: ~accumulator
  - mark: 1
  - space: 0
  - Internal par_err_q = (SAMPLED_BIT != expected). Go to STOP1.
- STOP1: stop_err_q = (SAMPLED_BIT==0). If latched STOP2=1 go to STOP2, else complete.
- STOP2: stop_err_q |= (SAMPLED_BIT==0). Complete.
- Complete (registered on the final stop strobe):
  - Next cycle: DATA_VALID=1 for exactly one cycle, BUSY=0, FSM in IDLE.
  - DATA_OUT, PAR_ERR and STOP_ERR update on that same edge and hold until the next completion or reset.
  - PAR_ERR=0 when the latched PARITY_EN was 0.
- Latency: DATA_VALID rises 1 cycle after the final stop-bit strobe.
- A frame completes even when it has errors. Downstream decides whether to discard it.
- Config inputs that change mid-frame have no effect until the next start bit.
- Back-to-back frames: a start strobe arriving in the cycle DATA_VALID is high is accepted normally. This holds because the FSM is already in IDLE.
- BIT_VALID on consecutive cycles is legal; every strobe is consumed.
- Illegal DATA_WIDTH (outside 5..9) must fail elaboration.

Decomposition:
- Shared package uart_pkg holds:
  - the PARITY_MODE encodings (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11);
  - the FSM state encoding;
  - the DATA_WIDTH legal-range constants.
- One natural sub-module: uart_parity_calc. It is the combinational expected-bit selector with inputs accumulator bit and PARITY_MODE and output the expected parity. uart_tx reuses it.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- DATA_WIDTH=8, even, one stop. Bits 0, 0xA5 LSB-first, parity 0, stop 1 -> DATA_VALID one cycle after the stop strobe, DATA_OUT=0xA5, PAR_ERR=0, STOP_ERR=0.
- Odd mode, 0x3C, parity bit sent as 0 (correct value is 1) -> DATA_OUT=0x3C, PAR_ERR=1, STOP_ERR=0.
- PARITY_EN=0, STOP2=1, 0x81, stops 1 then 0 -> DATA_OUT=0x81, PAR_ERR=0, STOP_ERR=1.
- Mark mode, 0x00 with parity bit 1; then space mode, 0xFF with parity bit 1 -> first frame PAR_ERR=0, second frame PAR_ERR=1.
- RST asserted after 4 data bits of 0x55, then a full frame 0x12 -> exactly one DATA_VALID with DATA_OUT=0x12. BUSY=0 the cycle after RST.
- DATA_WIDTH=7, PARITY_MODE flipped even->odd after the start bit, 0x7F with even parity 1 -> PAR_ERR=0, showing the latched config is used.
